// File: rtl/logic_unit_arb.sv
// Round-robin arbiter that shares one N-bit bitwise logic unit between four
// requesters and returns each result through a single registered slot.
module logic_unit_arb #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     req_valid,
   output logic [3:0]     req_ready,
   input  logic [11:0]    req_op,
   input  logic [4*N-1:0] req_a,
   input  logic [4*N-1:0] req_b,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [1:0]     resp_id,
   output logic [N-1:0]   resp_data,
   output logic           resp_zero
);

   logic [1:0]   r_ptr;
   logic         r_valid;
   logic [1:0]   r_id;
   logic [N-1:0] r_data;
   logic         r_zero;

   logic         w_free;
   logic         w_found;
   logic [1:0]   w_grant;
   logic [1:0]   w_idx;
   logic         w_accept;
   logic [2:0]   w_op;
   logic [N-1:0] w_a;
   logic [N-1:0] w_b;
   logic [N-1:0] w_and;
   logic [N-1:0] w_or;
   logic [N-1:0] w_xor;
   logic [N-1:0] w_result;

   assign w_free = !r_valid || resp_ready;

   // Search starts at the pointer and wraps, so the most recently served
   // requester is considered last.
   always_comb begin
      w_found = 1'b0;
      w_grant = r_ptr;
      w_idx   = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   // Gating with rst_n keeps every ready low for the whole reset period.
   assign w_accept  = w_free && w_found && rst_n;
   assign req_ready = w_accept ? (4'b0001 << w_grant) : 4'b0000;

   assign w_op = req_op[32'(w_grant)*3 +: 3];
   assign w_a  = req_a[32'(w_grant)*N +: N];
   assign w_b  = req_b[32'(w_grant)*N +: N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_gates
         assign w_and[gi] = w_a[gi] & w_b[gi];
         assign w_or[gi]  = w_a[gi] | w_b[gi];
         assign w_xor[gi] = w_a[gi] ^ w_b[gi];
      end
   endgenerate

   always_comb begin
      w_result = '0;
      case (w_op)
         3'b000:  w_result = w_and;
         3'b001:  w_result = w_or;
         3'b010:  w_result = w_xor;
         3'b011:  w_result = ~w_and;
         3'b100:  w_result = ~w_or;
         3'b101:  w_result = ~w_xor;
         3'b110:  w_result = ~w_a;
         default: w_result = w_a;
      endcase
   end

   // A drain and a refill in the same cycle simply take the accept branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= 2'd0;
         r_valid <= 1'b0;
         r_id    <= 2'd0;
         r_data  <= '0;
         r_zero  <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_id    <= w_grant;
         r_data  <= w_result;
         r_zero  <= (w_result == '0);
         r_ptr   <= w_grant + 2'd1;
      end else if (resp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign resp_valid = r_valid;
   assign resp_id    = r_id;
   assign resp_data  = r_data;
   assign resp_zero  = r_zero;

endmodule
